// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Registered ID-stage control unit for a five-stage RISC-V pipeline.
// Decodes the ID instruction and loads the control bundle into the ID/EX
// register under flush/stall control. It also runs the halt drain sequence.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   if_valid, instr   ID-stage instruction and its valid flag
//   stall, flush      ID/EX hold / bubble requests (flush wins)
//   ex_*              registered control bundle in EX
//   fetch_stop        front end must stop fetching (state != RUN)
//   halted            pipeline drained (state == HALTED)
module pipe_ctrl_unit #(
    parameter int DRAIN_CYCLES = 4,
    parameter int ENABLE_M     = 0,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_ALUSrc,
    output logic        ex_MemtoReg,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_Branch,
    output logic        ex_JalrSel,
    output logic [1:0]  ex_ALUOp,
    output logic [1:0]  ex_RWSel,
    output logic        ex_MulSel,
    output logic        ex_illegal,
    output logic        ex_halt,
    output logic        fetch_stop,
    output logic        halted
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    // Bundle layout: {valid, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    //                 Branch, JalrSel, ALUOp[1:0], RWSel[1:0], MulSel, illegal, halt}
    logic [14:0] dec_bundle;
    logic [14:0] ex_bundle_reg, ex_bundle_next;
    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       dec_illegal, dec_halt, is_mul_enc;
    logic       accept, start_halt;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct7      = instr[31:25];
    assign unused_bits = ^instr[24:7];
    assign is_mul_enc  = (opcode == OP_R) && (funct7 == 7'b0000001);

    // Combinational decode of the ID instruction into a full bundle.
    always_comb begin
        logic alusrc, memtoreg, regwrite, memread, memwrite, branch, jalrsel, mulsel;
        logic [1:0] aluop, rwsel;
        alusrc = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; memread = 1'b0;
        memwrite = 1'b0; branch = 1'b0; jalrsel = 1'b0; mulsel = 1'b0;
        aluop = 2'b00; rwsel = 2'b00;
        dec_illegal = 1'b0;
        dec_halt    = 1'b0;
        case (opcode)
            OP_R: begin
                regwrite = 1'b1; aluop = 2'b10;
                mulsel   = (ENABLE_M != 0) && is_mul_enc;
                dec_illegal = (ENABLE_M == 0) && is_mul_enc;
            end
            OP_LOAD:   begin alusrc = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; memread = 1'b1; end
            OP_STORE:  begin alusrc = 1'b1; memwrite = 1'b1; end
            OP_IMM:    begin alusrc = 1'b1; regwrite = 1'b1; aluop = 2'b10; end
            OP_BRANCH: begin branch = 1'b1; aluop = 2'b01; end
            OP_JAL:    begin regwrite = 1'b1; branch = 1'b1; aluop = 2'b11; rwsel = 2'b01; end
            OP_JALR:   begin alusrc = 1'b1; regwrite = 1'b1; jalrsel = 1'b1; rwsel = 2'b01; end
            OP_LUI:    begin regwrite = 1'b1; aluop = 2'b11; rwsel = 2'b10; end
            OP_AUIPC:  begin regwrite = 1'b1; rwsel = 2'b11; end
            OP_HALT:   dec_halt = 1'b1;
            default:   dec_illegal = 1'b1;
        endcase
        // Illegal and HALT carry no datapath controls at all.
        if (dec_illegal || dec_halt) begin
            alusrc = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; memread = 1'b0;
            memwrite = 1'b0; branch = 1'b0; jalrsel = 1'b0; mulsel = 1'b0;
            aluop = 2'b00; rwsel = 2'b00;
        end
        dec_bundle = {1'b1, alusrc, memtoreg, regwrite, memread, memwrite,
                      branch, jalrsel, aluop, rwsel, mulsel, dec_illegal, dec_halt};
    end

    assign accept     = !flush && !stall && if_valid && (state_reg == ST_RUN);
    assign start_halt = accept && (dec_halt || ((ILLEGAL_HALT != 0) && dec_illegal));

    // ID/EX register next value: flush > stall > load.
    always_comb begin
        ex_bundle_next = 15'd0;
        if (flush)
            ex_bundle_next = 15'd0;
        else if (stall)
            ex_bundle_next = ex_bundle_reg;
        else if (if_valid && (state_reg == ST_RUN))
            ex_bundle_next = dec_bundle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex_bundle_reg <= 15'd0;
        else
            ex_bundle_reg <= ex_bundle_next;
    end

    // Halt FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Halt FSM: next state. The drain counter ignores stall and flush.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (start_halt) begin
                    state_next = ST_DRAIN;
                    cnt_next   = CW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1))
                    state_next = ST_HALTED;
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Halt FSM: outputs decoded from registered state only.
    always_comb begin
        fetch_stop = (state_reg != ST_RUN);
        halted     = (state_reg == ST_HALTED);
    end

    assign {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
            ex_Branch, ex_JalrSel, ex_ALUOp, ex_RWSel, ex_MulSel, ex_illegal, ex_halt} = ex_bundle_reg;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = 32'd0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two instances share stimulus: defaults, and M-enabled/illegal-halt/short drain.
    localparam int DC [2] = '{4, 2};
    localparam int EM [2] = '{0, 1};
    localparam int IH [2] = '{0, 1};

    logic [14:0] act_b [2];
    logic        act_fs [2];
    logic        act_h [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic v, a, m2r, rw, mr, mw, br, js, mul, ill, hlt, fs, h;
            logic [1:0] aop, rws;
            pipe_ctrl_unit #(.DRAIN_CYCLES(DC[gi]), .ENABLE_M(EM[gi]), .ILLEGAL_HALT(IH[gi])) u_dut (
                .clk(clk), .reset(reset), .if_valid(if_valid), .instr(instr),
                .stall(stall), .flush(flush),
                .ex_valid(v), .ex_ALUSrc(a), .ex_MemtoReg(m2r), .ex_RegWrite(rw),
                .ex_MemRead(mr), .ex_MemWrite(mw), .ex_Branch(br), .ex_JalrSel(js),
                .ex_ALUOp(aop), .ex_RWSel(rws), .ex_MulSel(mul), .ex_illegal(ill),
                .ex_halt(hlt), .fetch_stop(fs), .halted(h)
            );
            assign act_b[gi]  = {v, a, m2r, rw, mr, mw, br, js, aop, rws, mul, ill, hlt};
            assign act_fs[gi] = fs;
            assign act_h[gi]  = h;
        end
    endgenerate

    // Bundle bit weights: {valid,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,JalrSel,ALUOp,RWSel,MulSel,illegal,halt}
    localparam logic [14:0] B_V = 15'h4000, B_AS = 15'h2000, B_M2R = 15'h1000, B_RW = 15'h0800;
    localparam logic [14:0] B_MR = 15'h0400, B_MW = 15'h0200, B_BR = 15'h0100, B_JS = 15'h0080;
    localparam logic [14:0] ALU01 = 15'h0020, ALU10 = 15'h0040, ALU11 = 15'h0060;
    localparam logic [14:0] RWS01 = 15'h0008, RWS10 = 15'h0010, RWS11 = 15'h0018;
    localparam logic [14:0] B_MUL = 15'h0004, B_ILL = 15'h0002, B_HLT = 15'h0001;

    // What an accepted instruction must put in EX, straight from the opcode table.
    function automatic logic [14:0] model_dec(input logic [31:0] ins, input int en_m);
        case (ins[6:0])
            7'h33: begin
                if (ins[31:25] == 7'b0000001)
                    return (en_m != 0) ? (B_V | B_RW | ALU10 | B_MUL) : (B_V | B_ILL);
                return B_V | B_RW | ALU10;
            end
            7'h03: return B_V | B_AS | B_M2R | B_RW | B_MR;
            7'h23: return B_V | B_AS | B_MW;
            7'h13: return B_V | B_AS | B_RW | ALU10;
            7'h63: return B_V | B_BR | ALU01;
            7'h6F: return B_V | B_RW | B_BR | ALU11 | RWS01;
            7'h67: return B_V | B_AS | B_RW | B_JS | RWS01;
            7'h37: return B_V | B_RW | ALU11 | RWS10;
            7'h17: return B_V | B_RW | RWS11;
            7'h7F: return B_V | B_HLT;
            default: return B_V | B_ILL;
        endcase
    endfunction

    // Model: expected EX bundle plus edges elapsed since halt acceptance (-1 = none).
    logic [14:0] dec_m [2];
    logic [14:0] exp_b [2];
    int          since [2];

    always_comb begin
        for (int k = 0; k < 2; k++) dec_m[k] = model_dec(instr, EM[k]);
    end

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                exp_b[k] <= 15'd0;
                since[k] <= -1;
            end else begin
                if (since[k] >= 0) since[k] <= since[k] + 1;
                if (flush)
                    exp_b[k] <= 15'd0;
                else if (!stall) begin
                    if (if_valid && since[k] < 0) begin
                        exp_b[k] <= dec_m[k];
                        if (dec_m[k][0] || (IH[k] != 0 && dec_m[k][1])) since[k] <= 0;
                    end else
                        exp_b[k] <= 15'd0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_bundle[%0d]", k), 32'(act_b[k]), 32'(exp_b[k]));
            chk($sformatf("model_fetch_stop[%0d]", k), 32'(act_fs[k]), 32'(since[k] >= 0));
            chk($sformatf("model_halted[%0d]", k), 32'(act_h[k]), 32'(since[k] >= DC[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h00000033, I_LW = 32'h00012083, I_SW = 32'h00112023;
    localparam logic [31:0] I_BEQ = 32'h00208063, I_JAL = 32'h008000EF, I_JALR = 32'h000080E7;
    localparam logic [31:0] I_LUI = 32'h000010B7, I_AUIPC = 32'h00001097, I_HALT = 32'h0000007F;
    localparam logic [31:0] I_MUL = 32'h02000033, I_CUST = 32'h0000000B;

    logic [31:0] prog [7];

    initial begin
        prog = '{I_LW, I_SW, I_BEQ, I_JAL, I_JALR, I_LUI, I_AUIPC};
        #1 reset = 1'b1;
        #2;
        chk("reset_bundle", 32'(act_b[0]), 32'h0);
        chk("reset_fetch_stop", 32'(act_fs[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic decode.
        if_valid = 1'b1; instr = I_ADD;
        tick();
        $display("txn add bundle=%h", act_b[0]);
        chk("add_bundle", 32'(act_b[0]), 32'h4840);
        foreach (prog[i]) begin
            instr = prog[i];
            tick();
            $display("txn instr=%h bundle=%h", instr, act_b[0]);
        end
        chk("auipc_bundle", 32'(act_b[0]), 32'h4818);

        // Stall holds LW for three cycles, then stall+flush bubbles.
        instr = I_LW;
        tick();
        stall = 1'b1; instr = I_ADD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_lw", 32'(act_b[0]), 32'h7C00);
        end
        flush = 1'b1;
        tick();
        $display("txn stall+flush bundle=%h", act_b[0]);
        chk("stall_flush_bubble", 32'(act_b[0]), 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Multiply with M disabled / enabled.
        instr = I_MUL;
        tick();
        $display("txn mul bundle0=%h bundle1=%h", act_b[0], act_b[1]);
        chk("mul_illegal_m0", 32'(act_b[0]), 32'h4002);
        chk("mul_enabled_m1", 32'(act_b[1]), 32'h4844);

        // Stalled HALT is not accepted; flushed HALT is never accepted.
        instr = I_ADD;
        tick();
        stall = 1'b1; instr = I_HALT;
        tick(); tick();
        chk("stalled_halt_hold", 32'(act_b[0]), 32'h4840);
        chk("stalled_halt_fs", 32'(act_fs[0]), 32'h0);
        flush = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        $display("txn flushed halt fs=%b", act_fs[0]);
        chk("flushed_halt_fs", 32'(act_fs[0]), 32'h0);
        flush = 1'b0;

        // HALT then reset mid-drain.
        instr = I_HALT;
        tick();
        $display("txn halt bundle=%h fs=%b", act_b[0], act_fs[0]);
        chk("halt_bundle", 32'(act_b[0]), 32'h4001);
        chk("halt_fetch_stop", 32'(act_fs[0]), 32'h1);
        instr = I_ADD;
        tick();
        chk("halt_pulse_end", 32'(act_b[0]), 32'h0);
        tick();
        chk("drain2_halted_inst1", 32'(act_h[1]), 32'h1);
        chk("drain4_not_yet", 32'(act_h[0]), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_fs", 32'(act_fs[0]), 32'h0);
        chk("async_reset_halted", 32'(act_h[1]), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_reset_add", 32'(act_b[0]), 32'h4840);

        // Full drain, with stall and flush during DRAIN.
        instr = I_HALT;
        tick();
        instr = I_ADD;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_n3_not_halted", 32'(act_h[0]), 32'h0);
        tick();
        $display("txn drain done halted=%b bundle=%h", act_h[0], act_b[0]);
        chk("drain_n4_halted", 32'(act_h[0]), 32'h1);
        chk("halted_ignores_ifvalid", 32'(act_b[0]), 32'h0);
        tick(); tick();
        chk("halted_sticky", 32'(act_h[0]), 32'h1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;

        // Illegal opcode; instance 1 halts on it.
        instr = I_CUST;
        tick();
        $display("txn custom bundle0=%h fs0=%b fs1=%b", act_b[0], act_fs[0], act_fs[1]);
        chk("cust_illegal0", 32'(act_b[0]), 32'h4002);
        chk("cust_illegal1", 32'(act_b[1]), 32'h4002);
        chk("cust_fs0", 32'(act_fs[0]), 32'h0);
        chk("cust_fs1", 32'(act_fs[1]), 32'h1);
        instr = I_ADD;
        tick(); tick();
        chk("cust_halted1", 32'(act_h[1]), 32'h1);
        chk("cust_inst0_runs", 32'(act_b[0]), 32'h4840);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered, parametrised control unit for the five-stage RISC-V pipeline. It decodes the instruction in ID and drives the full control bundle into the ID/EX register, applying stall and flush. It detects illegal encodings and optional M-extension multiplies. A HALT opcode triggers a drain sequence: fetch stops immediately, and a halted flag is raised once the back-end stages have emptied.

## Interface
Parameters:
- DRAIN_CYCLES, 4: cycles from HALT acceptance to `halted`; legal range ≥1.
- ENABLE_M, 0: 1 decodes R-type with funct7=0000001 as multiply.
- ILLEGAL_HALT, 0: 1 makes an accepted illegal instruction start the halt sequence.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- if_valid  in  1  instr holds a valid ID-stage instruction.
- instr  in  32  ID instruction; opcode=[6:0], funct7=[31:25].
- stall  in  1  hold ID/EX contents.
- flush  in  1  load a bubble into ID/EX.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_JalrSel  out  1 each  control bits.
- ex_ALUOp  out  2  ALU operation class.
- ex_RWSel  out  2  write-back source select.
- ex_MulSel  out  1  multiply instruction.
- ex_illegal  out  1  illegal encoding.
- ex_halt  out  1  HALT instruction in EX.
- fetch_stop  out  1  front-end must stop fetching.
- halted  out  1  pipeline drained.

## Operation
- Decode (combinational, on instr):
  - ALUSrc = LOAD(0000011), STORE(0100011), OPIMM(0010011), JALR(1100111).
  - MemtoReg = MemRead = LOAD. MemWrite = STORE.
  - RegWrite = R(0110011), LOAD, OPIMM, JAL(1101111), JALR, LUI(0110111), AUIPC(0010111).
  - ALUOp = 01 for BRANCH(1100011); 10 for R and OPIMM; 11 for JAL and LUI; 00 otherwise.
  - Branch = BRANCH or JAL. JalrSel = JALR.
  - RWSel = 01 for JAL/JALR; 10 for LUI; 11 for AUIPC; 00 otherwise.
  - HALT = 1111111.
- Illegal: any opcode not listed above. Also R-type with funct7=0000001 when ENABLE_M=0. An illegal instruction loads all controls 0 and ex_illegal=1, with ex_valid=1.
- MulSel = ENABLE_M & R & funct7==0000001. The other controls follow normal R-type decode.
- HALT loads all controls 0, with ex_halt=1 and ex_valid=1.
- ID/EX update priority: reset > flush > stall > load.
  - flush: ex_valid and all ex_* outputs are 0.
  - stall (no flush): all ex_* outputs hold.
  - load: if if_valid and state==RUN, load the decoded bundle with ex_valid=1; otherwise load a bubble.
- Accepted instruction: one loaded with ex_valid=1.
- Halt FSM states: RUN, DRAIN, HALTED.
  - RUN→DRAIN on acceptance of HALT, or of an illegal instruction when ILLEGAL_HALT=1. The drain counter loads DRAIN_CYCLES.
  - DRAIN: counter decrements every cycle, regardless of stall or flush. At counter==1, go to HALTED.
  - HALTED: held until reset.
- fetch_stop = (state≠RUN). halted = (state==HALTED). Both are decoded from registered state, so they are glitch-free.
- In DRAIN or HALTED, if_valid is ignored and only bubbles load. stall/flush still apply.
- Counter width: $clog2(DRAIN_CYCLES+1).

## Timing
- Decode-to-EX latency is 1 cycle: instr at edge N appears on ex_* after edge N.
- Halt timing, with HALT accepted at edge N:
  - ex_halt=1 and fetch_stop=1 after edge N.
  - ex_halt returns to 0 after edge N+1 unless stalled.
  - halted=1 after edge N+DRAIN_CYCLES.
- Stalled HALT: not accepted until the cycle stall drops. A HALT flushed in its loading cycle is never accepted, and the state stays RUN.
- Simultaneous stall and flush: flush wins.
- Reset asserted at any time (including mid-DRAIN): all outputs go to 0 and the state goes to RUN asynchronously. First load occurs on the first edge after release.

## Test plan
- Reset, then if_valid=1 with instr=0x00000033 (add) → after 1 edge: ex_valid=1, RegWrite=1, ALUOp=10, all other controls 0.
- Sequence LW/SW/BEQ/JAL/JALR/LUI/AUIPC → each bundle matches the decode list. Example: AUIPC gives RegWrite=1, ALUOp=00, RWSel=11.
- stall=1 for 3 cycles holding LW, then flush=1 and stall=1 in the same cycle → ex_* held for 3 cycles, then ex_valid=0 with all controls 0.
- HALT at edge 10 with DRAIN_CYCLES=4 → fetch_stop=1 from edge 10, ex_halt pulses for 1 cycle, halted=1 after edge 14, later if_valid instructions are not loaded. Reset at edge 12 → all outputs 0 and normal decode resumes.
- instr=0x02000033 (mul): with ENABLE_M=0 → ex_illegal=1, controls 0. With ENABLE_M=1 → ex_MulSel=1, RegWrite=1, ALUOp=10.
- Opcode 0x0B with ILLEGAL_HALT=1 → ex_illegal=1, fetch_stop=1 next cycle, halted after DRAIN_CYCLES edges.
